pe2_ctrl: RTL and testbench
===========================

PE2_CTRL -- requirements
Module: pe2_ctrl

Interface
REQ-001 SHALL have parameter LOGN, default 9: log2 of transform length N (N=512).
REQ-002 SHALL have parameter RD_LAT, default 1: coefficient/twiddle memory read latency in cycles.
REQ-003 SHALL have parameter PE_LAT, default 7: butterfly-unit latency, PE inputs to bf_upper/bf_lower.
REQ-004 SHALL have ports, in this order:
 clk  input  1  single clock, rising edge.
 rst  input  1  synchronous, active-low reset.
 start  input  1  begin a transform; sampled only in IDLE.
 mode  input  1  0=NTT (Cooley-Tukey), 1=INTT (Gentleman-Sande); latched on start.
 rd_en  output  1  read strobe for coefficient and twiddle memories.
 rd_addr_u  output  LOGN  address of upper operand.
 rd_addr_v  output  LOGN  address of lower operand.
 tw_addr  output  LOGN  twiddle ROM address.
 sel_ntt  output  1  butterfly mode select to PE, equals latched mode.
 wr_en  output  1  write-back strobe.
 wr_addr_u  output  LOGN  write address for bf_upper result.
 wr_addr_v  output  LOGN  write address for bf_lower result.
 busy  output  1  high from start acceptance until done.
 done  output  1  one-cycle completion pulse.

Function
REQ-005 SHALL define D = RD_LAT + PE_LAT (8 by default) as the issue-to-writeback delay.
REQ-006 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE: start=1 -> latch mode, stage s=0, index j=0, go to RUN; start=0 -> stay.
REQ-008 RUN: each cycle rd_en=1, issue butterfly (s,j), then j=j+1; at j=N/2-1 go to DRAIN and clear j to 0.
REQ-009 DRAIN: hold rd_en=0 for exactly D cycles; then, if s<LOGN-1, s=s+1 and go to RUN; else go to DONE.
REQ-010 DONE: done=1 and busy=1 for one cycle, then go to IDLE with busy=0.
REQ-011 NTT addressing: h=N>>(s+1); rd_addr_u=((j/h)*2h)+(j mod h); rd_addr_v=rd_addr_u+h; tw_addr=(1<<s)+(j/h).
REQ-012 INTT addressing: h=1<<s; rd_addr_u=((j>>s)<<(s+1))+(j mod h); rd_addr_v=rd_addr_u+h; tw_addr=(N>>(s+1))+(j>>s).
REQ-013 All divisions and modulos SHALL be power-of-two shifts/masks; all address arithmetic modulo 2^LOGN, no carry out.
REQ-014 SHALL delay rd_en, rd_addr_u and rd_addr_v through a D-deep shift pipeline to produce wr_en, wr_addr_u and wr_addr_v exactly D cycles after issue.
REQ-015 sel_ntt SHALL be constant while busy=1; it SHALL be held at its last value in IDLE.
REQ-016 start while busy=1 SHALL be ignored, with no effect on counters or mode.
REQ-017 Per stage, the last write SHALL occur in the final DRAIN cycle and the next stage's first read in the following cycle, so no read-after-write hazard exists.
REQ-018 Total start-to-done latency SHALL be LOGN*(N/2+D)+1 cycles, i.e. 2377 with default parameters; done is asserted in that cycle.
REQ-019 When rd_en=0, rd address outputs SHALL be 0; when wr_en=0, wr address outputs SHALL be 0.

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE, s=0, j=0, and latched mode=0.
REQ-021 Reset SHALL set rd_en, wr_en, busy, done, sel_ntt and all address outputs to 0, and flush the writeback pipeline.
REQ-022 Reset mid-transform SHALL abort it: no wr_en in any later cycle, and no done pulse.

Verification
REQ-023 NTT, start at cycle 0 -> cycle 1: rd_addr_u=0, rd_addr_v=256, tw_addr=1; cycle 9: wr_en=1, wr_addr_u=0, wr_addr_v=256.
REQ-024 NTT stage s=8, j=5 -> rd_addr_u=10, rd_addr_v=11, tw_addr=261; INTT s=0, j=5 -> rd_addr_u=10, rd_addr_v=11, tw_addr=261.
REQ-025 Full NTT run -> exactly 2304 rd_en and 2304 wr_en cycles; the done pulse arrives 2377 cycles after start; each stage writes every address 0..511 exactly once.
REQ-026 start pulsed at cycle 100 of a run, with mode toggled -> no change in address sequence, sel_ntt, or completion time.
REQ-027 rst=0 at cycle 300 -> next cycle busy=0 and wr_en=0, and wr_en stays 0; a new start afterwards -> a normal run from s=0.

Source files
------------

// File: rtl/pe2_ctrl.sv
// Address/control sequencer for a radix-2 NTT/INTT butterfly unit.
// Issues one butterfly per cycle per stage and drains the PE pipeline between stages.
module pe2_ctrl #(
  parameter int LOGN   = 9,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_u,
  output logic [LOGN-1:0] rd_addr_v,
  output logic [LOGN-1:0] tw_addr,
  output logic            sel_ntt,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_u,
  output logic [LOGN-1:0] wr_addr_v,
  output logic            busy,
  output logic            done
);

  localparam int D    = RD_LAT + PE_LAT;
  localparam int HALF = (1 << LOGN) / 2;
  localparam int SW   = $clog2(LOGN + 1);
  localparam int CW   = $clog2(D + 1);

  localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
  localparam logic [LOGN-1:0] J_LAST = LOGN'(HALF - 1);
  localparam logic [CW-1:0]   C_LAST = CW'(D - 1);
  localparam logic [LOGN-1:0] ONE    = LOGN'(1);
  localparam logic [LOGN-1:0] HALF_N = LOGN'(HALF);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   s, s_nx;
  logic [LOGN-1:0] j, j_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            mode_q, mode_nx;
  logic            issue;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      s      <= '0;
      j      <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nx;
      s      <= s_nx;
      j      <= j_nx;
      cnt    <= cnt_nx;
      mode_q <= mode_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    j_nx     = j;
    cnt_nx   = cnt;
    mode_nx  = mode_q;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_nx  = mode;
          s_nx     = '0;
          j_nx     = '0;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (j == J_LAST) begin
          j_nx     = '0;
          cnt_nx   = '0;
          state_nx = DRAIN;
        end else begin
          j_nx = j + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == C_LAST) begin
          cnt_nx = '0;
          if (s < S_LAST) begin
            s_nx     = s + 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = DONE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Both modes share one u/v formula; only the half-span exponent differs
  // (LOGN-1-s for NTT, s for INTT).
  logic [SW-1:0]   hb;
  logic [LOGN-1:0] lo_mask, addr_u, addr_v, addr_tw;

  always_comb begin
    hb      = mode_q ? s : (S_LAST - s);
    lo_mask = (ONE << hb) - ONE;
    addr_u  = ((j >> hb) << (hb + 1'b1)) | (j & lo_mask);
    addr_v  = addr_u | (ONE << hb);
    addr_tw = mode_q ? ((HALF_N >> s) + (j >> s)) : ((ONE << s) + (j >> hb));
  end

  assign rd_en     = issue;
  assign rd_addr_u = issue ? addr_u  : '0;
  assign rd_addr_v = issue ? addr_v  : '0;
  assign tw_addr   = issue ? addr_tw : '0;
  assign sel_ntt   = mode_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  logic [D-1:0]    wen_pipe;
  logic [LOGN-1:0] wu_pipe [D];
  logic [LOGN-1:0] wv_pipe [D];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wen_pipe <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        wu_pipe[i] <= '0;
        wv_pipe[i] <= '0;
      end
    end else begin
      wen_pipe[0] <= rd_en;
      wu_pipe[0]  <= rd_addr_u;
      wv_pipe[0]  <= rd_addr_v;
      for (int unsigned i = 1; i < D; i++) begin
        wen_pipe[i] <= wen_pipe[i-1];
        wu_pipe[i]  <= wu_pipe[i-1];
        wv_pipe[i]  <= wv_pipe[i-1];
      end
    end
  end

  assign wr_en     = wen_pipe[D-1];
  assign wr_addr_u = wu_pipe[D-1];
  assign wr_addr_v = wv_pipe[D-1];

endmodule

// File: tb/tb_pe2_ctrl.sv
// Scoreboard bench for pe2_ctrl: an arithmetic address model fills expectation
// queues at start; a negedge monitor pops and compares whatever the DUT presents.
module tb_pe2_ctrl;
  localparam int LOGN  = 9;
  localparam int N     = 1 << LOGN;
  localparam int D     = 8;
  localparam int STAGE = N / 2 + D;
  localparam int LAT   = LOGN * STAGE + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            mode = 1'b0;
  logic            rd_en, wr_en, sel_ntt, busy, done;
  logic [LOGN-1:0] rd_addr_u, rd_addr_v, tw_addr, wr_addr_u, wr_addr_v;

  pe2_ctrl #(.LOGN(LOGN), .RD_LAT(1), .PE_LAT(7)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .rd_en(rd_en), .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v), .tw_addr(tw_addr),
    .sel_ntt(sel_ntt), .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_v(wr_addr_v),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int c;
    int u;
    int v;
    int tw;
    int sel;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: butterfly (s,j) of an N-point transform, by plain division/modulo.
  function automatic ev_t model(input int s, input int j, input int m, input int c);
    ev_t e;
    int  h;
    h     = m ? (1 << s) : (N >> (s + 1));
    e.u   = ((j / h) * 2 * h + (j % h)) % N;
    e.v   = (e.u + h) % N;
    e.tw  = m ? ((N >> (s + 1)) + j / h) % N : ((1 << s) + j / h) % N;
    e.sel = m;
    e.c   = c;
    return e;
  endfunction

  task automatic plan(input int c0, input int m);
    ev_t e;
    for (int s = 0; s < LOGN; s++)
      for (int j = 0; j < N / 2; j++) begin
        e = model(s, j, m, c0 + s * STAGE + j);
        rd_q.push_back(e);
        e.c = e.c + D;
        wr_q.push_back(e);
      end
    done_q.push_back(c0 + LAT - 1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_cycle", cyc, e.c);
        chk("rd_addr_u", int'(rd_addr_u), e.u);
        chk("rd_addr_v", int'(rd_addr_v), e.v);
        chk("tw_addr", int'(tw_addr), e.tw);
        chk("sel_ntt", int'(sel_ntt), e.sel);
        chk("busy_run", int'(busy), 1);
      end
    end else begin
      chk("rd_addr_idle", int'(rd_addr_u) + int'(rd_addr_v) + int'(tw_addr), 0);
    end
    if (wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr_u", int'(wr_addr_u), e.u);
        chk("wr_addr_v", int'(wr_addr_v), e.v);
      end
    end else begin
      chk("wr_addr_idle", int'(wr_addr_u) + int'(wr_addr_v), 0);
    end
    if (done) begin
      done_seen = 1;
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
      chk("busy_done", int'(busy), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_q();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic launch(input int m, output int c0);
    tick($urandom_range(1, 6));
    start = 1'b1;
    mode  = m[0];
    tick(1);
    c0    = cyc;
    start = 1'b0;
    mode  = 1'($urandom);
    done_seen = 0;
    plan(c0, m);
  endtask

  task automatic do_run(input int m, input bit pulse);
    int c0;
    launch(m, c0);
    if (pulse) begin
      while (cyc < c0 + 99) tick(1);
      start = 1'b1;
      mode  = ~m[0];
      tick(1);
      start = 1'b0;
    end
    for (int k = 0; k < LAT + 20 && !done_seen; k++) tick(1);
    chk("done_seen", int'(done_seen), 1);
    chk("busy_idle", int'(busy), 0);
    chk("sel_hold", int'(sel_ntt), m);
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    flush_q();
  endtask

  initial begin
    int c0;
    tick(3);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sel", int'(sel_ntt), 0);
    chk("rst_addr", int'(rd_addr_u) + int'(rd_addr_v) + int'(tw_addr)
                    + int'(wr_addr_u) + int'(wr_addr_v), 0);
    rst = 1'b1;

    do_run(0, 0);
    do_run(1, 0);
    do_run(int'($urandom_range(0, 1)), 1);

    // abort mid-transform
    launch(int'($urandom_range(0, 1)), c0);
    while (cyc < c0 + 298) tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    flush_q();
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    for (int k = 0; k < 40; k++) begin
      chk("abort_wr_quiet", int'(wr_en), 0);
      chk("abort_no_done", int'(done), 0);
      tick(1);
    end

    do_run(int'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
